// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_controller
// Brief    : Control FSM for a 2-way set-associative cache (hit, dirty-victim
//            writeback, refill). Optional perf counters via CACHE_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_controller #(
    parameter int CNT_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_read,
    input  logic mem_write,
    output logic mem_resp,
    input  logic hit,
    input  logic hit_way,
    input  logic valid_0,
    input  logic valid_1,
    input  logic dirty_0,
    input  logic dirty_1,
    input  logic lru,
    output logic way_sel,
    output logic load_data,
    output logic load_tag,
    output logic load_valid,
    output logic load_dirty,
    output logic load_lru,
    output logic valid_in,
    output logic dirty_in,
    output logic lru_in,
    output logic data_sel,
    output logic pmem_addr_sel,
    output logic pmem_read,
    output logic pmem_write,
    input  logic pmem_resp
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
`endif
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_COMPARE   = 2'd1;
    localparam logic [1:0] c_WRITEBACK = 2'd2;
    localparam logic [1:0] c_ALLOCATE  = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_victim;
    logic       w_victim_next;
    logic       r_refill;
    logic       w_refill_next;
    logic       w_req;
    logic       w_victim_dirty;

    assign w_req          = mem_read | mem_write;
    assign w_victim_dirty = lru ? (valid_1 & dirty_1) : (valid_0 & dirty_0);

    // Async reset forces IDLE, whose outputs are all zero, so every output
    // (including pmem requests) drops as soon as rst rises.
    always_comb begin
        w_state_next  = r_state;
        w_victim_next = r_victim;
        w_refill_next = r_refill;
        mem_resp      = 1'b0;
        way_sel       = 1'b0;
        load_data     = 1'b0;
        load_tag      = 1'b0;
        load_valid    = 1'b0;
        load_dirty    = 1'b0;
        load_lru      = 1'b0;
        valid_in      = 1'b0;
        dirty_in      = 1'b0;
        lru_in        = 1'b0;
        data_sel      = 1'b0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_req) w_state_next = c_COMPARE;
            end
            c_COMPARE: begin
                if (!w_req) begin
                    // Request abandoned mid-miss: finish quietly.
                    w_state_next  = c_IDLE;
                    w_refill_next = 1'b0;
                end else if (hit) begin
                    mem_resp      = 1'b1;
                    load_lru      = 1'b1;
                    way_sel       = hit_way;
                    lru_in        = ~hit_way;
                    if (mem_write) begin
                        load_data  = 1'b1;
                        load_dirty = 1'b1;
                        dirty_in   = 1'b1;
                    end
                    w_state_next  = c_IDLE;
                    w_refill_next = 1'b0;
                end else begin
                    w_victim_next = lru;
                    w_state_next  = w_victim_dirty ? c_WRITEBACK : c_ALLOCATE;
                end
            end
            c_WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = r_victim;
                if (pmem_resp) begin
                    load_dirty   = 1'b1;
                    w_state_next = c_ALLOCATE;
                end
            end
            c_ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = r_victim;
                if (pmem_resp) begin
                    load_data     = 1'b1;
                    data_sel      = 1'b1;
                    load_tag      = 1'b1;
                    load_valid    = 1'b1;
                    valid_in      = 1'b1;
                    load_dirty    = 1'b1;
                    w_refill_next = 1'b1;
                    w_state_next  = c_COMPARE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_victim <= 1'b0;
            r_refill <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_victim <= w_victim_next;
            r_refill <= w_refill_next;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] r_hit_count;
    logic [CNT_WIDTH-1:0] r_miss_count;
    logic [CNT_WIDTH-1:0] r_wb_count;
    logic                 w_hit_evt;
    logic                 w_miss_evt;
    logic                 w_wb_evt;

    // Post-refill re-check hits are part of the miss, not new hits.
    assign w_hit_evt  = (r_state == c_COMPARE) & w_req & hit & ~r_refill;
    assign w_miss_evt = (r_state == c_COMPARE) & w_req & ~hit;
    assign w_wb_evt   = (r_state == c_WRITEBACK) & pmem_resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            if (w_hit_evt && (r_hit_count != '1))   r_hit_count  <= r_hit_count + c_CNT_ONE;
            if (w_miss_evt && (r_miss_count != '1)) r_miss_count <= r_miss_count + c_CNT_ONE;
            if (w_wb_evt && (r_wb_count != '1))     r_wb_count   <= r_wb_count + c_CNT_ONE;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
    assign wb_count   = r_wb_count;
`else
    // CNT_WIDTH only sizes the optional counters; nothing to build here.
    if (CNT_WIDTH > 0) begin : g_no_perf_cnt
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_controller
// Brief    : Transaction-level reference model and per-cycle output compare
//            for cache_controller (perf counters checked if CACHE_PERF_CNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_read = 1'b0, mem_write = 1'b0, mem_resp;
    logic hit = 1'b0, hit_way = 1'b0;
    logic valid_0 = 1'b0, valid_1 = 1'b0, dirty_0 = 1'b0, dirty_1 = 1'b0, lru = 1'b0;
    logic way_sel, load_data, load_tag, load_valid, load_dirty, load_lru;
    logic valid_in, dirty_in, lru_in, data_sel, pmem_addr_sel, pmem_read, pmem_write;
    logic pmem_resp = 1'b0;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    cache_controller #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit(hit), .hit_way(hit_way),
        .valid_0(valid_0), .valid_1(valid_1), .dirty_0(dirty_0), .dirty_1(dirty_1),
        .lru(lru), .way_sel(way_sel),
        .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
        .load_dirty(load_dirty), .load_lru(load_lru),
        .valid_in(valid_in), .dirty_in(dirty_in), .lru_in(lru_in),
        .data_sel(data_sel), .pmem_addr_sel(pmem_addr_sel),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
`ifdef CACHE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic mem_resp, way_sel, load_data, load_tag, load_valid, load_dirty, load_lru;
        logic valid_in, dirty_in, lru_in, data_sel, pmem_addr_sel, pmem_read, pmem_write;
    } outv_t;

    localparam outv_t L_RD_HIT_W1 = '{mem_resp:1'b1, way_sel:1'b1, load_lru:1'b1, default:1'b0};
    localparam outv_t L_WR_HIT_W0 = '{mem_resp:1'b1, load_data:1'b1, load_dirty:1'b1,
                                      dirty_in:1'b1, load_lru:1'b1, lru_in:1'b1, default:1'b0};
    localparam outv_t L_RD_HIT_W0 = '{mem_resp:1'b1, load_lru:1'b1, lru_in:1'b1, default:1'b0};
    localparam outv_t L_ALLOC_W1  = '{way_sel:1'b1, pmem_read:1'b1, default:1'b0};
    localparam outv_t L_FILL_W1   = '{way_sel:1'b1, pmem_read:1'b1, load_data:1'b1, data_sel:1'b1,
                                      load_tag:1'b1, load_valid:1'b1, valid_in:1'b1,
                                      load_dirty:1'b1, default:1'b0};
    localparam outv_t L_ALLOC_W0  = '{pmem_read:1'b1, default:1'b0};
    localparam outv_t L_ZERO      = '{default:1'b0};

    outv_t act, exp_v;
    string exp_nm = "";
    bit    exp_on = 1'b0;
    int    checks = 0, passes = 0;
    int    m_hits = 0, m_miss = 0, m_wb = 0;

    assign act = {mem_resp, way_sel, load_data, load_tag, load_valid, load_dirty, load_lru,
                  valid_in, dirty_in, lru_in, data_sel, pmem_addr_sel, pmem_read, pmem_write};

    always @(negedge clk) begin
        if (exp_on) begin
            checks++;
            if (act === exp_v) passes++;
            else $display("FAIL %s: got %b want %b", exp_nm, act, exp_v);
        end
    end

    function automatic outv_t f_hit(input bit wr, input bit w);
        outv_t e = '0;
        e.mem_resp = 1'b1; e.load_lru = 1'b1; e.way_sel = w; e.lru_in = ~w;
        if (wr) begin e.load_data = 1'b1; e.load_dirty = 1'b1; e.dirty_in = 1'b1; end
        return e;
    endfunction

    function automatic outv_t f_wb(input bit v, input bit resp);
        outv_t e = '0;
        e.pmem_write = 1'b1; e.pmem_addr_sel = 1'b1; e.way_sel = v;
        e.load_dirty = resp;
        return e;
    endfunction

    function automatic outv_t f_alloc(input bit v, input bit resp);
        outv_t e = '0;
        e.pmem_read = 1'b1; e.way_sel = v;
        if (resp) begin
            e.load_data = 1'b1; e.data_sel = 1'b1; e.load_tag = 1'b1;
            e.load_valid = 1'b1; e.valid_in = 1'b1; e.load_dirty = 1'b1;
        end
        return e;
    endfunction

    task automatic step(input outv_t e, input string nm);
        exp_v  = e;
        exp_nm = nm;
        exp_on = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint got, input longint want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got %0d want %0d", nm, got, want);
    endtask

    task automatic idle(input int n);
        mem_read = 1'b0; mem_write = 1'b0;
        for (int i = 0; i < n; i++) begin
            pmem_resp = 1'($urandom_range(0, 1));
            hit       = 1'($urandom_range(0, 1));
            step(L_ZERO, "idle_gap");
        end
        pmem_resp = 1'b0;
    endtask

    // One CPU access from IDLE to mem_resp; expected trace built from the access rules.
    task automatic txn(input bit wr, input bit is_hit, input bit hway, input bit [1:0] v,
                       input bit [1:0] d, input bit lr, input int wlat, input int rlat);
        bit vic;
        mem_write = wr;
        mem_read  = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
        hit = is_hit; hit_way = hway;
        {valid_1, valid_0} = v; {dirty_1, dirty_0} = d; lru = lr;
        pmem_resp = 1'($urandom_range(0, 1));
        step(L_ZERO, "txn_idle");
        pmem_resp = 1'($urandom_range(0, 1));
        if (is_hit) begin
            m_hits++;
            step(f_hit(wr, hway), "txn_hit");
        end else begin
            m_miss++;
            vic = lr;
            step(L_ZERO, "txn_miss");
            if (v[vic] && d[vic]) begin
                for (int i = 1; i <= wlat; i++) begin
                    pmem_resp = (i == wlat);
                    lru = 1'($urandom_range(0, 1));
                    step(f_wb(vic, i == wlat), "txn_wb");
                end
                m_wb++;
            end
            for (int i = 1; i <= rlat; i++) begin
                pmem_resp = (i == rlat);
                lru = 1'($urandom_range(0, 1));
                step(f_alloc(vic, i == rlat), "txn_alloc");
            end
            pmem_resp = 1'($urandom_range(0, 1));
            hit = 1'b1; hit_way = vic; lru = 1'($urandom_range(0, 1));
            step(f_hit(wr, vic), "txn_recheck");
        end
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        step(L_ZERO, "reset_hold");
        rst = 1'b0;
        step(L_ZERO, "post_reset");

        // Read hit, way 1
        mem_read = 1'b1; hit = 1'b1; hit_way = 1'b1;
        step(L_ZERO, "rd_hit_idle");
        step(L_RD_HIT_W1, "rd_hit_w1");
        m_hits++;
        idle(1);

        // Write hit, way 0
        mem_write = 1'b1; hit = 1'b1; hit_way = 1'b0;
        step(L_ZERO, "wr_hit_idle");
        step(L_WR_HIT_W0, "wr_hit_w0");
        m_hits++;
        idle(1);

        // Clean miss into way 1, pmem latency 5, lru flips during refill
        mem_read = 1'b1; hit = 1'b0; lru = 1'b1; valid_1 = 1'b0; valid_0 = 1'b1; dirty_0 = 1'b1;
        step(L_ZERO, "cm_idle");
        step(L_ZERO, "cm_compare");
        m_miss++;
        lru = 1'b0;
        for (int i = 0; i < 4; i++) step(L_ALLOC_W1, "cm_alloc_wait");
        pmem_resp = 1'b1;
        step(L_FILL_W1, "cm_fill");
        pmem_resp = 1'b0; hit = 1'b1; hit_way = 1'b1;
        step(L_RD_HIT_W1, "cm_recheck");
        idle(1);

        // Dirty miss on way 0
        txn(1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 3, 2);
        idle(1);

        // Spurious pmem_resp in IDLE, then a single-pulse read hit
        pmem_resp = 1'b1;
        step(L_ZERO, "spur_idle");
        mem_read = 1'b1; hit = 1'b1; hit_way = 1'b0;
        step(L_ZERO, "spur_req_idle");
        step(L_RD_HIT_W0, "spur_hit");
        m_hits++;
        mem_read = 1'b0;
        step(L_ZERO, "spur_single_pulse");
        pmem_resp = 1'b0;

        // Request dropped mid-refill: refill completes, no mem_resp
        mem_read = 1'b1; hit = 1'b0; lru = 1'b1; valid_1 = 1'b0;
        step(L_ZERO, "drop_idle");
        step(L_ZERO, "drop_compare_miss");
        m_miss++;
        mem_read = 1'b0;
        step(L_ALLOC_W1, "drop_alloc");
        pmem_resp = 1'b1;
        step(L_FILL_W1, "drop_fill");
        pmem_resp = 1'b0; hit = 1'b1;
        step(L_ZERO, "drop_recompare");
        step(L_ZERO, "drop_back_idle");

        // Async reset mid-ALLOCATE
        mem_read = 1'b1; hit = 1'b0; lru = 1'b0; valid_0 = 1'b0;
        step(L_ZERO, "ra_idle");
        step(L_ZERO, "ra_compare");
        step(L_ALLOC_W0, "ra_alloc");
        exp_v = L_ZERO; exp_nm = "ra_in_rst";
        rst = 1'b1;
        #1;
        chk("ra_pmem_read_drop", longint'(pmem_read), 0);
        mem_read = 1'b0;
        step(L_ZERO, "ra_in_rst");
        rst = 1'b0;
        m_hits = 0; m_miss = 0; m_wb = 0;
        step(L_ZERO, "ra_after_rst");
        txn(1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1, 1);

        // Randomized accesses
        for (int n = 0; n < 300; n++) begin
            idle($urandom_range(0, 2));
            txn(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom_range(1, 4), $urandom_range(1, 4));
        end
        idle(2);

`ifdef CACHE_PERF_CNT_EN
        chk("hit_count", longint'(hit_count), m_hits);
        chk("miss_count", longint'(miss_count), m_miss);
        chk("wb_count", longint'(wb_count), m_wb);
`endif
        exp_on = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
